// File: rtl/calc_sram.sv
// calc_sram: single-port-pair SRAM with power-on zero sweep, error flag and access counters
package calculator_pkg;
  parameter int ADDR_W        = 5;
  parameter int MEM_WORD_SIZE = 64;
endpackage

module calc_sram
  import calculator_pkg::*;
#(
  parameter int DEPTH          = 2**ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     read,
  input  logic [ADDR_W-1:0]        r_addr,
  output logic [MEM_WORD_SIZE-1:0] r_data,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [MEM_WORD_SIZE-1:0] w_data,
  output logic                     ready_o,
  output logic                     err_o,
  output logic [15:0]              rd_cnt_o,
  output logic [15:0]              wr_cnt_o
);
  typedef enum logic {INIT, READY} state_t;
  localparam logic [ADDR_W:0]   LIM    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH-1);
  localparam state_t            RST_ST = CLEAR_ON_RESET ? INIT : READY;
  state_t                     r_state, w_next;
  logic [ADDR_W-1:0]          r_sweep;
  logic [MEM_WORD_SIZE-1:0]   r_mem [2**ADDR_W];
  logic                       w_rd_ok, w_wr_ok, w_err;
  assign w_rd_ok = (r_state == READY) && !read  && ({1'b0, r_addr} < LIM);
  assign w_wr_ok = (r_state == READY) && !write && ({1'b0, w_addr} < LIM);
  assign w_err   = (!read && !w_rd_ok) || (!write && !w_wr_ok);
  assign ready_o = (r_state == READY);
  // leave INIT on the edge that clears the last word
  always_comb begin
    w_next = r_state;
    if (r_state == INIT && r_sweep == LAST) w_next = READY;
  end
  // state, sweep pointer, read data, error flag and counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= RST_ST;
      r_sweep  <= '0;
      r_data   <= '0;
      err_o    <= 1'b0;
      rd_cnt_o <= '0;
      wr_cnt_o <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == INIT) r_sweep <= r_sweep + 1'b1;
      if (w_rd_ok) r_data <= (w_wr_ok && w_addr == r_addr) ? w_data : r_mem[r_addr];
      if (w_err) err_o <= 1'b1;
      if (w_rd_ok && rd_cnt_o != 16'hFFFF) rd_cnt_o <= rd_cnt_o + 16'd1;
      if (w_wr_ok && wr_cnt_o != 16'hFFFF) wr_cnt_o <= wr_cnt_o + 16'd1;
    end
  end
  // array is not reset; writes are blocked while reset is held so pending accesses are discarded
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (r_state == INIT) r_mem[r_sweep] <= '0;
      else if (w_wr_ok) r_mem[w_addr] <= w_data;
    end
  end
endmodule

// File: tb/tb_calc_sram.sv
// tb_calc_sram: directed self-checking bench for calc_sram (DEPTH=16, CLEAR_ON_RESET=1)
module tb_calc_sram;
  import calculator_pkg::*;
  logic                     clk_i = 1'b0;
  logic                     rst_ni;
  logic                     read = 1'b1, write = 1'b1;
  logic [ADDR_W-1:0]        r_addr = '0, w_addr = '0;
  logic [MEM_WORD_SIZE-1:0] w_data = '0;
  logic [MEM_WORD_SIZE-1:0] r_data;
  logic                     ready_o, err_o;
  logic [15:0]              rd_cnt_o, wr_cnt_o;
  int checks = 0, failures = 0;

  calc_sram #(.DEPTH(16), .CLEAR_ON_RESET(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .read(read), .r_addr(r_addr), .r_data(r_data),
    .write(write), .w_addr(w_addr), .w_data(w_data), .ready_o(ready_o), .err_o(err_o),
    .rd_cnt_o(rd_cnt_o), .wr_cnt_o(wr_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic wait_ready(output int n);
    n = 0;
    while (ready_o !== 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (ready_o !== 1'b1) begin failures++; $display("FAIL wait_ready timeout got=%b want=1", ready_o); end
  endtask

  task automatic reset_dut;
    read = 1'b1;
    write = 1'b1;
    #2 rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    read = 1'b0; r_addr = a;
    @(negedge clk_i);
    read = 1'b1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [MEM_WORD_SIZE-1:0] d);
    write = 1'b0; w_addr = a; w_data = d;
    @(negedge clk_i);
    write = 1'b1;
  endtask

  task automatic rw(input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] wa, input logic [MEM_WORD_SIZE-1:0] d);
    read = 1'b0; r_addr = ra; write = 1'b0; w_addr = wa; w_data = d;
    @(negedge clk_i);
    read = 1'b1; write = 1'b1;
  endtask

  task automatic test_reset;
    int n;
    rst_ni = 1'b0;
    #1;
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err_o); end
    checks++; if (r_data !== '0) begin failures++; $display("FAIL reset_rdata got=%h want=0", r_data); end
    checks++; if (rd_cnt_o !== 16'd0 || wr_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%h/%h want=0/0", rd_cnt_o, wr_cnt_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_ready(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL init_len got=%0d want=16", n); end
    for (int a = 0; a < 16; a++) begin
      rd(ADDR_W'(a));
      checks++; if (r_data !== '0) begin failures++; $display("FAIL clear_read addr=%0d got=%h want=0", a, r_data); end
    end
    checks++; if (rd_cnt_o !== 16'd16) begin failures++; $display("FAIL clear_rdcnt got=%0d want=16", rd_cnt_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL clear_err got=%b want=0", err_o); end
  endtask

  task automatic test_write_read;
    int n;
    reset_dut();
    wait_ready(n);
    wr(5'd4, 64'h0000_0005_0000_0003);
    rd(5'd4);
    checks++; if (r_data !== 64'h0000_0005_0000_0003) begin failures++; $display("FAIL wr_rd_data got=%h want=0000000500000003", r_data); end
    checks++; if (wr_cnt_o !== 16'd1) begin failures++; $display("FAIL wr_rd_wrcnt got=%0d want=1", wr_cnt_o); end
    checks++; if (rd_cnt_o !== 16'd1) begin failures++; $display("FAIL wr_rd_rdcnt got=%0d want=1", rd_cnt_o); end
  endtask

  task automatic test_same_cycle;
    rw(5'd7, 5'd7, 64'hAA);
    checks++; if (r_data !== 64'hAA) begin failures++; $display("FAIL same_addr_wf got=%h want=aa", r_data); end
    checks++; if (rd_cnt_o !== 16'd2 || wr_cnt_o !== 16'd2) begin failures++; $display("FAIL same_addr_cnt got=%0d/%0d want=2/2", rd_cnt_o, wr_cnt_o); end
    rw(5'd4, 5'd9, 64'h99);
    checks++; if (r_data !== 64'h0000_0005_0000_0003) begin failures++; $display("FAIL diff_addr_rd got=%h want=0000000500000003", r_data); end
    rd(5'd7);
    checks++; if (r_data !== 64'hAA) begin failures++; $display("FAIL same_addr_stored got=%h want=aa", r_data); end
    rd(5'd9);
    checks++; if (r_data !== 64'h99) begin failures++; $display("FAIL diff_addr_stored got=%h want=99", r_data); end
    checks++; if (rd_cnt_o !== 16'd5 || wr_cnt_o !== 16'd3) begin failures++; $display("FAIL dual_cnt got=%0d/%0d want=5/3", rd_cnt_o, wr_cnt_o); end
  endtask

  task automatic test_init_access;
    int n;
    reset_dut();
    repeat (2) @(negedge clk_i);
    rd(5'd4);
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL init_rd_err got=%b want=1", err_o); end
    checks++; if (r_data !== '0) begin failures++; $display("FAIL init_rd_data got=%h want=0", r_data); end
    checks++; if (rd_cnt_o !== 16'd0) begin failures++; $display("FAIL init_rd_cnt got=%0d want=0", rd_cnt_o); end
    wait_ready(n);
    checks++; if (n !== 13) begin failures++; $display("FAIL init_rest_len got=%0d want=13", n); end
    wr(5'd2, 64'h55);
    rd(5'd2);
    checks++; if (r_data !== 64'h55) begin failures++; $display("FAIL oor_setup got=%h want=55", r_data); end
    rd(5'd20);
    checks++; if (r_data !== 64'h55) begin failures++; $display("FAIL oor_rd_data got=%h want=55", r_data); end
    checks++; if (rd_cnt_o !== 16'd1) begin failures++; $display("FAIL oor_rd_cnt got=%0d want=1", rd_cnt_o); end
    wr(5'd20, 64'hDEAD);
    checks++; if (wr_cnt_o !== 16'd1) begin failures++; $display("FAIL oor_wr_cnt got=%0d want=1", wr_cnt_o); end
    rd(5'd4);
    checks++; if (r_data !== '0) begin failures++; $display("FAIL oor_no_alias got=%h want=0", r_data); end
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b want=1", err_o); end
  endtask

  task automatic test_reset_mid_init;
    int n;
    reset_dut();
    wait_ready(n);
    wr(5'd0, 64'h1);
    rd(5'd0);
    checks++; if (r_data !== 64'h1) begin failures++; $display("FAIL mid_setup got=%h want=1", r_data); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (r_data !== '0 || rd_cnt_o !== 16'd0 || wr_cnt_o !== 16'd0) begin failures++; $display("FAIL async_clear got=%h/%0d/%0d want=0/0/0", r_data, rd_cnt_o, wr_cnt_o); end
    checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL async_ready got=%b want=0", ready_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    rd(5'd1);
    repeat (6) @(negedge clk_i);
    checks++; if (err_o !== 1'b1 || ready_o !== 1'b0) begin failures++; $display("FAIL mid_pre got=%b/%b want=1/0", err_o, ready_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (err_o !== 1'b0 || ready_o !== 1'b0) begin failures++; $display("FAIL mid_async got=%b/%b want=0/0", err_o, ready_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_ready(n);
    checks++; if (n !== 16) begin failures++; $display("FAIL mid_restart_len got=%0d want=16", n); end
    rd(5'd0);
    checks++; if (r_data !== '0) begin failures++; $display("FAIL mid_addr0 got=%h want=0", r_data); end
  endtask

  task automatic test_back_to_back;
    int n;
    reset_dut();
    wait_ready(n);
    read = 1'b0; r_addr = 5'd3;
    repeat (65534) @(negedge clk_i);
    checks++; if (rd_cnt_o !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h want=fffe", rd_cnt_o); end
    @(negedge clk_i);
    checks++; if (rd_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL sat_hit got=%h want=ffff", rd_cnt_o); end
    repeat (5) @(negedge clk_i);
    read = 1'b1;
    checks++; if (rd_cnt_o !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h want=ffff", rd_cnt_o); end
    checks++; if (r_data !== '0 || err_o !== 1'b0) begin failures++; $display("FAIL sat_data got=%h/%b want=0/0", r_data, err_o); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_cycle();
    test_init_access();
    test_reset_mid_init();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
